fact_ratio_seq: RTL
===================

// Module: fact_ratio_seq
// PURPOSE
//   Multi-cycle, parametrised engine computing result = n * n! / (2n + 1), with the quotient truncated.
//   Uses a start/ready/done handshake and reports arithmetic overflow.
//   Iterative: one multiply per cycle, then a bit-serial restoring divide.
//   Successor to the single-cycle factorial-ratio block in the arithmetic exercise set.
// PARAMETERS
//   N_W    4   width of operand n (n in 0 .. 2^N_W-1)
//   RES_W  32  width of accumulator, divider and result
// PORTS
//   clk       in   1      clock, all state updates on posedge
//   reset     in   1      synchronous, active-low
//   start     in   1      request; accepted only when ready=1
//   n         in   N_W    operand, sampled in the accept cycle only
//   ready     out  1      1 in IDLE, else 0
//   done      out  1      one-cycle pulse; result/overflow valid from this cycle
//   result    out  RES_W  quotient, held until next done
//   overflow  out  1      1 if any product exceeded RES_W bits, held with result
// BEHAVIOUR
//   - Reset (clk edge with reset=0): state=IDLE, ready=1, done=0, result=0, overflow=0.
//   - Reset mid-operation aborts the operation. No done pulse is produced.
//   - Accept: cycle T with ready=1 and start=1 latches n.
//   - start while ready=0 is ignored; no queuing.
//   - FSM states: IDLE -> FACT -> SCALE -> DIV -> DONE -> IDLE.
//   - n==0 takes IDLE -> DONE directly: done at T+1, result=0, overflow=0.
//   - FACT: acc starts at 1 and idx at 2. Each cycle does acc = acc*idx, idx++.
//     It runs k = max(n-1,0) cycles; n==1 skips straight to SCALE.
//   - SCALE: 1 cycle, acc = acc*n.
//   - DIV: RES_W cycles of restoring division of acc by d = 2n+1.
//     d is formed at width N_W+2 and zero-extended; d is never 0.
//   - DONE: 1 cycle with done=1 and result/overflow registered; ready=0. IDLE follows.
//   - Latency for n>=1: done at cycle T + k + RES_W + 3.
//   - A new start is accepted the cycle after done.
//   - Products are computed at 2*RES_W bits. Nonzero upper half sets the internal sticky ovf, cleared on accept.
//   - Without saturation, acc keeps the lower RES_W bits (wraps mod 2^RES_W).
//   - overflow output = sticky ovf at DONE.
// CONFIGURATION
//   FACT_RATIO_SAT_EN defined:
//     - On overflow, result = {RES_W{1'b1}} and DIV is skipped (DONE follows SCALE).
//     - Latency on overflow is T + k + 3.
//   FACT_RATIO_SAT_EN undefined: the wrapped accumulator is divided normally; overflow flag only.
// STRUCTURE
//   - Package fact_ratio_pkg holds:
//     - FSM state enum (IDLE, FACT, SCALE, DIV, DONE), 3-bit encoding;
//     - default widths as localparams;
//     - function divisor_of(n) returning 2n+1.
//   - Sub-module fact_div_seq is a RES_W-cycle restoring divider.
//     - Ports: clk, reset, go, dividend, divisor, quo, busy.
//     - Instantiated once; the top FSM waits on its busy.
// TESTING
//   1. reset=0 for 2 cycles while start=1 -> ready=1, done=0, result=0, overflow=0 throughout.
//   2. N_W=4, RES_W=32, n=5, start -> done exactly at T+39, result=54, overflow=0. Checks latency formula.
//   3. n=0 -> done at T+1, result=0. n=1 -> result=0 (1/3). n=3 -> result=2 (18/7).
//   4. n=11 -> result=19090643, overflow=0. n=12 -> overflow=1.
//      Result without macro = (5748019200 mod 2^32)/25 = 58122076; with FACT_RATIO_SAT_EN = 32'hFFFFFFFF.
//   5. n=7, then start pulses and n changes during busy -> ignored.
//      result=5040*7/15=2352, then back-to-back n=2 the cycle after done -> result=0 (4/5).
//   6. reset=0 asserted mid-DIV -> next cycle IDLE, ready=1, no done. A following n=4 gives result=10 (96/9).

Source files
------------

// File: rtl/fact_ratio_pkg.sv
// rtl/fact_ratio_pkg.sv - shared types, default widths and divisor helper for the factorial-ratio engine
//
// Contents:
//   state_t       FSM state encoding (IDLE, FACT, SCALE, DIV, DONE), 3 bits
//   N_W_DEF       default operand width
//   RES_W_DEF     default accumulator / divider / result width
//   divisor_of()  returns 2n+1; operand widths up to 30 bits are supported

package fact_ratio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FACT  = 3'd1,
        ST_SCALE = 3'd2,
        ST_DIV   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int N_W_DEF   = 4;
    localparam int RES_W_DEF = 32;

    // 2n+1 is odd, so the divisor can never be zero.
    function automatic logic [31:0] divisor_of(input logic [31:0] n);
        return (n << 1) + 32'd1;
    endfunction

endpackage

// File: rtl/fact_div_seq.sv
// rtl/fact_div_seq.sv - RES_W-cycle bit-serial restoring divider
//
// Ports:
//   clk       clock, all state updates on posedge
//   reset     synchronous, active-low
//   go        load dividend/divisor and start; restarts any division in flight
//   dividend  RES_W-bit numerator, sampled when go=1
//   divisor   RES_W-bit denominator, sampled when go=1, must be nonzero
//   quo       quotient; valid once busy has fallen after a go
//   busy      1 during the RES_W iteration cycles following go

module fact_div_seq #(
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [RES_W-1:0] dividend,
    input  logic [RES_W-1:0] divisor,
    output logic [RES_W-1:0] quo,
    output logic             busy
);

    localparam int CNT_W = $clog2(RES_W);

    logic [RES_W-1:0] rem_q;
    logic [RES_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_q;

    // The quotient register doubles as the dividend shift register: each step
    // shifts its MSB into the partial remainder and its LSB receives a quotient bit.
    logic [RES_W:0]   rem_sh;
    logic             fit;
    logic [RES_W-1:0] rem_next;

    assign rem_sh   = {rem_q, quo[RES_W-1]};
    assign fit      = (rem_sh >= {1'b0, div_q});
    assign rem_next = fit ? RES_W'(rem_sh - {1'b0, div_q}) : rem_sh[RES_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            quo   <= '0;
            busy  <= 1'b0;
        end else if (go) begin
            rem_q <= '0;
            div_q <= divisor;
            quo   <= dividend;
            cnt_q <= CNT_W'(RES_W - 1);
            busy  <= 1'b1;
        end else if (busy) begin
            rem_q <= rem_next;
            quo   <= {quo[RES_W-2:0], fit};
            if (cnt_q == '0) begin
                busy <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fact_ratio_seq.sv
// rtl/fact_ratio_seq.sv - iterative engine computing n * n! / (2n+1) with overflow reporting
//
// Ports:
//   clk       clock, all state updates on posedge
//   reset     synchronous, active-low
//   start     request, accepted only while ready=1
//   n         N_W-bit operand, sampled in the accept cycle
//   ready     1 while idle
//   done      one-cycle pulse; result/overflow valid from this cycle
//   result    truncated quotient, held until the next done
//   overflow  1 if any intermediate product exceeded RES_W bits
//
// Build option:
//   FACT_RATIO_SAT_EN  on overflow, result saturates to all ones and the divider
//                      is not started (DONE follows SCALE after one pass-through cycle)

module fact_ratio_seq
    import fact_ratio_pkg::*;
#(
    parameter int N_W   = N_W_DEF,
    parameter int RES_W = RES_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    output logic             ready,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             overflow
);

    state_t             state_q;
    logic [N_W-1:0]     n_q;
    logic [N_W:0]       idx_q;
    logic [RES_W-1:0]   acc_q;
    logic               ovf_q;
    logic               ready_q;
    logic               done_q;
    logic [RES_W-1:0]   result_q;
    logic               overflow_q;

    logic [N_W:0]       mul_op;
    logic [2*RES_W-1:0] prod;
    logic               ovf_now;
    logic               div_go;
    logic [RES_W-1:0]   div_quo;
    logic               div_busy;

    // One shared multiplier: FACT multiplies by the running index, SCALE by n.
    assign mul_op  = (state_q == ST_SCALE) ? {1'b0, n_q} : idx_q;
    assign prod    = (2*RES_W)'(acc_q) * (2*RES_W)'(mul_op);
    assign ovf_now = |prod[2*RES_W-1:RES_W];

    // The divider is launched straight from the SCALE product so that the
    // final accumulator value is not needed a cycle later.
`ifdef FACT_RATIO_SAT_EN
    assign div_go = (state_q == ST_SCALE) && !(ovf_q || ovf_now);
`else
    assign div_go = (state_q == ST_SCALE);
`endif

    fact_div_seq #(
        .RES_W (RES_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .go       (div_go),
        .dividend (prod[RES_W-1:0]),
        .divisor  (RES_W'(divisor_of(32'(n_q)))),
        .quo      (div_quo),
        .busy     (div_busy)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        n_q     <= n;
                        acc_q   <= RES_W'(1);
                        idx_q   <= (N_W+1)'(2);
                        ovf_q   <= 1'b0;
                        ready_q <= 1'b0;
                        if (n == '0) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            result_q   <= '0;
                            overflow_q <= 1'b0;
                        end else if (n == N_W'(1)) begin
                            state_q <= ST_SCALE;
                        end else begin
                            state_q <= ST_FACT;
                        end
                    end
                end
                ST_FACT: begin
                    acc_q <= prod[RES_W-1:0];
                    ovf_q <= ovf_q | ovf_now;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == {1'b0, n_q}) begin
                        state_q <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    acc_q   <= prod[RES_W-1:0];
                    ovf_q   <= ovf_q | ovf_now;
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    // busy is already high in the first DIV cycle when the
                    // divider was launched, so falling busy marks completion.
                    if (!div_busy) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        overflow_q <= ovf_q;
`ifdef FACT_RATIO_SAT_EN
                        result_q   <= ovf_q ? {RES_W{1'b1}} : div_quo;
`else
                        result_q   <= div_quo;
`endif
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule
